// File: rtl/mux_scan_pkg.sv
// Shared constants and state type for the mux scan sequencer.
// Optional parity trailer bit: MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned SW = $clog2(N);

`ifdef MUX_SCAN_PARITY_EN
  localparam int unsigned CW = SW + 2;
`else
  localparam int unsigned CW = SW + 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    PAR  = 2'd3
  } state_e;

endpackage

// File: rtl/mux_scan_seq.sv
// Sequencer that latches a word onto an external 16:1 mux and steps sel from
// first to last, streaming each selected bit out with valid/ready handshake.
// Optional parity trailer bit: MUX_SCAN_PARITY_EN.
module mux_scan_seq
  import mux_scan_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  word_in,
  input  logic [SW-1:0] first_sel,
  input  logic [SW-1:0] last_sel,
  output logic [N-1:0]  mux_in,
  output logic [SW-1:0] sel,
  input  logic          y_in,
  output logic          bit_out,
  output logic          bit_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_cnt
);

  state_e        state_q, state_d;
  logic [N-1:0]  mux_in_q, mux_in_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_valid_q, bit_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef MUX_SCAN_PARITY_EN
  logic          par_q, par_d;
`endif

  // Next-state and registered-output decode; flags follow the next state.
  always_comb begin
    state_d  = state_q;
    mux_in_d = mux_in_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
`ifdef MUX_SCAN_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mux_in_d = word_in;
          sel_d    = first_sel;
          last_d   = last_sel;
          cnt_d    = '0;
`ifdef MUX_SCAN_PARITY_EN
          par_d    = 1'b0;
`endif
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          cnt_d = cnt_q + CW'(1);
`ifdef MUX_SCAN_PARITY_EN
          par_d = par_q ^ y_in;
`endif
          if (sel_q == last_q) begin
`ifdef MUX_SCAN_PARITY_EN
            state_d = PAR;
`else
            state_d = DONE;
`endif
          end else begin
            sel_d = sel_q + SW'(1);
          end
        end
      end
`ifdef MUX_SCAN_PARITY_EN
      PAR: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MUX_SCAN_PARITY_EN
    bit_valid_d = (state_d == SCAN) || (state_d == PAR);
`else
    bit_valid_d = (state_d == SCAN);
`endif
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_in_q    <= '0;
      sel_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mux_in_q    <= mux_in_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Serial data: zero-latency passthrough of the mux in SCAN, parity in PAR.
  always_comb begin
    bit_out = 1'b0;
    if (state_q == SCAN) bit_out = y_in;
`ifdef MUX_SCAN_PARITY_EN
    if (state_q == PAR)  bit_out = par_q;
`endif
  end

  assign mux_in    = mux_in_q;
  assign sel       = sel_q;
  assign bit_cnt   = cnt_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Upstream sequencer for the 16:1 bit mux (`in[15:0]`, `sel[3:0]`, `y`).
- Latches a parallel word, drives it onto the mux data bus, and steps `sel` from a programmed first channel to a programmed last channel.
- Forwards each selected bit downstream as a serial stream with valid/ready flow control.
- Converts a parallel word into an ordered, back-pressurable bit stream through the existing mux.

Parameters:
- N, 16, number of mux channels (width of the data word).
- SW, $clog2(N) = 4, select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- word_in  in  N  parallel word; captured on an accepted start.
- first_sel  in  SW  first channel to emit; captured on an accepted start.
- last_sel  in  SW  last channel to emit; captured on an accepted start.
- mux_in  out  N  registered word; drives the mux `in`.
- sel  out  SW  registered channel select; drives the mux `sel`.
- y_in  in  1  mux output `y`; combinational function of mux_in/sel.
- bit_out  out  1  serial data; equals y_in in SCAN.
- bit_valid  out  1  bit_out is valid.
- out_ready  in  1  downstream accepts bit_out.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at end of scan.
- bit_cnt  out  SW+1  bits transferred in the current scan.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; mux_in=0, sel=0, bit_cnt=0, bit_valid=0, done=0, busy=0.
- States: IDLE, SCAN, DONE (plus PAR when the optional feature is enabled).
- IDLE:
  - start=1 → capture word_in into mux_in, first_sel into sel and into an internal last register; clear bit_cnt; next state SCAN.
  - start=0 → hold.
- SCAN:
  - bit_valid=1, bit_out=y_in (combinational passthrough; the mux has zero latency).
  - A transfer occurs on a cycle with bit_valid && out_ready; bit_cnt increments on each transfer.
  - On transfer with sel==last → next state DONE, sel holds.
  - Otherwise sel<=sel+1, modulo N. Wrap 15→0 is legal, so first_sel>last_sel scans across the wrap.
  - first_sel==last_sel → exactly one bit emitted.
  - A full scan (first=0, last=15) emits 16 bits, so bit_cnt=16; bit_cnt is SW+1 bits wide for this reason.
  - out_ready=0 → sel, bit_cnt and bit_out are all stable; bit_valid stays high and must not drop before the transfer.
- DONE: done=1 for exactly one cycle, bit_valid=0; next state IDLE. mux_in, sel and bit_cnt hold until the next accepted start.
- Latency: start edge → first bit_valid the next cycle. With out_ready tied high, a K-bit scan has done high in cycle K+1 after start.
- start while busy: ignored; no effect on the scan.
- start asserted in the DONE cycle: ignored; a new start is accepted from IDLE one cycle later.
- rst mid-scan: all state and outputs take reset values on that edge. No done pulse, no further bits.
- Inputs word_in, first_sel and last_sel may change freely after capture.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - After the last data transfer, the FSM enters PAR instead of DONE.
  - PAR drives bit_out = even-parity bit (XOR of all transferred bits) with bit_valid=1, under the same out_ready rule.
  - On transfer, PAR → DONE.
  - bit_cnt counts the parity bit (max 17); bit_cnt widens to SW+2.
  - The parity accumulator clears on an accepted start.
- Undefined: no PAR state and no accumulator; SCAN goes straight to DONE.

Decomposition:
- Package mux_scan_pkg holds:
  - constants N=16 and SW=4;
  - state enum type (IDLE, SCAN, DONE, PAR).
- No sub-module. The mux stays a separate instance wired beside this block at the next level up and in the bench.

Test Plan:
- Basic scan: word_in=16'h3f0a, first=0, last=3, out_ready=1 → bits 0,1,0,1 on cycles 1–4, done on cycle 5, bit_cnt=4, busy low on cycle 6.
- Wrap-around: word_in=16'h3f0a, first=14, last=1 → sel sequence 14,15,0,1; bits 0,0,0,1; bit_cnt=4.
- Backpressure: same as the basic scan with out_ready low on cycles 2–3 → bit_out=1 and sel=1 held stable while bit_valid=1; all 4 bits delivered exactly once; done on cycle 7.
- Start while busy and reset: a second start with word_in=16'hffff during SCAN is ignored and the stream still reads 0,1,0,1. rst on cycle 2 → next cycle busy=0, bit_valid=0, sel=0, mux_in=0, and no done pulse.
- Single and full range:
  - first=last=6 with word_in=16'h0040 → one bit, value 1, then done.
  - first=0, last=15 with word_in=16'h3f0a → LSB-first 16-bit stream matching the word, bit_cnt=16.
- Parity (MUX_SCAN_PARITY_EN defined): basic scan → 0,1,0,1 followed by parity bit 0; done on cycle 6; bit_cnt=5. With first=0, last=2 → 0,1,0 followed by parity 1.
